fc_sequencer: RTL and testbench
===============================

Name: fc_sequencer

Overview:
Control unit for a time-multiplexed fully connected layer: one MAC, a 144-entry activation buffer, and a weight/bias ROM.
- Accepts the 9-channel pooled stream (16 beats) and generates the buffer write strobes.
- Then sequences all OUTPUT_NUM dot products one neuron at a time: address generation, accumulator clear/enable, bias add, result strobe.
- Sits between the last pooling stage and the classifier output.

Parameters:
IN_CH, 9, parallel input channels per beat
IN_LEN, 16, beats per frame; INPUT_NUM = IN_CH*IN_LEN = 144
OUTPUT_NUM, 10, output neurons
RD_LAT, 1, buffer/weight read latency in cycles (1..4)
ACC_W, 20, accumulator width (argmax compare only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
valid_in  in  1  input beat valid
in_ready  out  1  beat accepted when valid_in && in_ready
wr_en  out  1  buffer write strobe (combinational = valid_in && in_ready)
wr_col  out  $clog2(IN_LEN)  column written; datapath stores channel c at c*IN_LEN+wr_col
rd_addr  out  $clog2(INPUT_NUM)  buffer read address j
w_addr  out  $clog2(INPUT_NUM*OUTPUT_NUM)  weight address n*INPUT_NUM+j
mac_clr  out  1  accumulator clear
mac_en  out  1  accumulate product of read data
bias_add  out  1  add bias[out_idx] into accumulator
out_idx  out  $clog2(OUTPUT_NUM)  current neuron n
out_valid  out  1  accumulator holds final result for out_idx
frame_done  out  1  coincident with last out_valid of a frame
busy  out  1  state != LOAD
drop_err  out  1  sticky: valid_in seen while in_ready=0
acc_in  in  ACC_W  signed accumulator value (used only with FC_ARGMAX_EN)
class_id  out  $clog2(OUTPUT_NUM)  argmax result
class_valid  out  1  class_id strobe

Behaviour:
- Reset (asynchronous, active-high):
  - state=LOAD; all counters 0; in_ready=1.
  - All strobes 0; rd_addr=w_addr=out_idx=class_id=0; drop_err=0.
  - The RD_LAT pipeline is flushed.
  - Reset mid-frame abandons the frame. No partial out_valid or frame_done is emitted.
- Strobes are 1-cycle registered pulses unless stated otherwise.
- LOAD:
  - in_ready=1; col counter increments per accepted beat.
  - On the accept with col==IN_LEN-1: col→0, go to CLR.
  - Gaps in valid_in are allowed.
- CLR (1 cycle): mac_clr=1; j=0.
- MAC (INPUT_NUM cycles):
  - Each cycle issues rd_addr=j and w_addr=n*INPUT_NUM+j.
  - Internal issue flag is delayed RD_LAT cycles to form mac_en.
  - After j==INPUT_NUM-1, go to DRAIN.
- DRAIN (RD_LAT cycles): no new issue. The final mac_en occurs in the last DRAIN cycle.
- BIAS (1 cycle): bias_add=1, out_idx=n.
- EMIT (1 cycle): out_valid=1, out_idx=n.
  - If n==OUTPUT_NUM-1: frame_done=1, n→0, go to LOAD.
  - Else: n→n+1, go to CLR.
- Latency:
  - Per neuron: 1+INPUT_NUM+RD_LAT+2 cycles (148 at defaults).
  - Last input beat to first out_valid: 148 cycles. To frame_done: 1480 cycles.
- Handshake/overflow:
  - in_ready=0 in every state except LOAD.
  - valid_in while in_ready=0 is ignored: no write, no counter change. It sets drop_err, which clears only on rst.
  - valid_in on the EMIT cycle of the last neuron is dropped; in_ready rises the following cycle.
- mac_en and mac_clr never assert in the same cycle. bias_add never overlaps mac_en.
- out_idx stays constant from CLR through EMIT of each neuron.

Optional Feature:
FC_ARGMAX_EN:
- Defined:
  - acc_in is sampled on every out_valid. A running max and index are kept, initialised from neuron 0.
  - Update only on strictly greater (signed compare), so ties resolve to the lowest index.
  - class_valid pulses 1 cycle after frame_done, with class_id = argmax.
  - Running max is cleared on rst and at frame start.
- Undefined: acc_in ignored; class_id=0 and class_valid=0 constantly; no argmax registers are synthesized.

Test Plan:
- Reset, then 16 back-to-back beats → wr_en 16 cycles, wr_col 0..15, in_ready falls the cycle after beat 15; first mac_clr next cycle.
- Full frame, RD_LAT=1 → exactly 10 out_valid pulses with out_idx 0..9, spaced 148 cycles apart; frame_done with out_idx=9; 144 mac_en per neuron; w_addr for neuron 3 spans 432..575.
- RD_LAT=3 → per-neuron spacing 150; mac_en trails rd_addr issue by 3 cycles; bias_add follows the last mac_en by exactly 1 cycle.
- valid_in held high through compute → no wr_en after beat 15, drop_err=1; next frame's beats accepted starting the cycle after frame_done.
- rst asserted in neuron 5's MAC phase → outputs 0 asynchronously, in_ready=1 after release, no further out_valid; a fresh frame then produces out_idx 0..9 normally.
- FC_ARGMAX_EN, acc_in per neuron = {-5,100,7,100,-20000,3,0,99,1,2} → class_valid 1 cycle after frame_done, class_id=1 (tie with neuron 3 goes to the lower index).

Source files
------------

// File: rtl/fc_sequencer.sv
// rtl/fc_sequencer.sv - load/compute sequencer for a time-multiplexed fully connected layer
// Optional argmax over the neuron results is built when FC_ARGMAX_EN is defined.
module fc_sequencer #(
  parameter int IN_CH      = 9,
  parameter int IN_LEN     = 16,
  parameter int OUTPUT_NUM = 10,
  parameter int RD_LAT     = 1,
  parameter int ACC_W      = 20,
  localparam int INPUT_NUM = IN_CH * IN_LEN,
  localparam int COL_W     = $clog2(IN_LEN),
  localparam int J_W       = $clog2(INPUT_NUM),
  localparam int WA_W      = $clog2(INPUT_NUM * OUTPUT_NUM),
  localparam int N_W       = $clog2(OUTPUT_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             in_ready,
  output logic             wr_en,
  output logic [COL_W-1:0] wr_col,
  output logic [J_W-1:0]   rd_addr,
  output logic [WA_W-1:0]  w_addr,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             bias_add,
  output logic [N_W-1:0]   out_idx,
  output logic             out_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             drop_err,
  input  logic [ACC_W-1:0] acc_in,
  output logic [N_W-1:0]   class_id,
  output logic             class_valid
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    CLR   = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    BIAS  = 3'd4,
    EMIT  = 3'd5
  } state_t;

  localparam int D_W = 3;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_LEN - 1);
  localparam logic [J_W-1:0]   J_LAST   = J_W'(INPUT_NUM - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(OUTPUT_NUM - 1);
  localparam logic [D_W-1:0]   D_LAST   = D_W'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [WA_W-1:0]   wbase_q, wbase_d;
  logic [D_W-1:0]    dcnt_q, dcnt_d;
  logic              drop_q;
  logic [RD_LAT-1:0] iss_q, iss_d;
  logic              issue;

  assign in_ready   = (state_q == LOAD);
  assign wr_en      = valid_in && in_ready;
  assign wr_col     = col_q;
  assign rd_addr    = j_q;
  assign w_addr     = wbase_q + WA_W'(j_q);
  assign mac_clr    = (state_q == CLR);
  assign bias_add   = (state_q == BIAS);
  assign out_valid  = (state_q == EMIT);
  assign frame_done = out_valid && (n_q == N_LAST);
  assign out_idx    = n_q;
  assign busy       = (state_q != LOAD);
  assign drop_err   = drop_q;

  // Issue flag rides a RD_LAT-deep shift so mac_en lines up with returned read data.
  assign issue  = (state_q == MAC);
  assign mac_en = iss_q[RD_LAT-1];

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign iss_d = issue;
    end else begin : g_latn
      assign iss_d = {iss_q[RD_LAT-2:0], issue};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    j_d     = j_q;
    n_d     = n_q;
    wbase_d = wbase_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      LOAD: begin
        if (wr_en) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = CLR;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      CLR: begin
        j_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        if (j_q == J_LAST) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          j_d = j_q + J_W'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == D_LAST) begin
          state_d = BIAS;
        end else begin
          dcnt_d = dcnt_q + D_W'(1);
        end
      end
      BIAS: state_d = EMIT;
      EMIT: begin
        if (n_q == N_LAST) begin
          n_d     = '0;
          wbase_d = '0;
          state_d = LOAD;
        end else begin
          n_d     = n_q + N_W'(1);
          wbase_d = wbase_q + WA_W'(INPUT_NUM);
          state_d = CLR;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      col_q   <= '0;
      j_q     <= '0;
      n_q     <= '0;
      wbase_q <= '0;
      dcnt_q  <= '0;
      drop_q  <= 1'b0;
      iss_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      j_q     <= j_d;
      n_q     <= n_d;
      wbase_q <= wbase_d;
      dcnt_q  <= dcnt_d;
      drop_q  <= drop_q | (valid_in & ~in_ready);
      iss_q   <= iss_d;
    end
  end

`ifdef FC_ARGMAX_EN
  logic signed [ACC_W-1:0] max_q;
  logic [N_W-1:0]          cid_q;
  logic                    cv_q;

  // Strict compare keeps the lowest index on ties; neuron 0 always seeds the max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      cid_q <= '0;
      cv_q  <= 1'b0;
    end else begin
      cv_q <= frame_done;
      if (wr_en && (col_q == '0)) begin
        max_q <= '0;
      end else if (out_valid && ((n_q == '0) || ($signed(acc_in) > max_q))) begin
        max_q <= $signed(acc_in);
        cid_q <= n_q;
      end
    end
  end

  assign class_id    = cid_q;
  assign class_valid = cv_q;
`else
  logic unused_acc;
  assign unused_acc  = ^acc_in;
  assign class_id    = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_sequencer.sv
// tb/tb_fc_sequencer.sv - directed bench for fc_sequencer (RD_LAT=1 and RD_LAT=3 instances)
module tb_fc_sequencer;
  localparam int OUTPUT_NUM = 10;
  localparam int ACC_W      = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_a = 1'b0;
  logic valid_b = 1'b0;
  logic [ACC_W-1:0] acc_in = '0;
  logic sel = 1'b0;

  logic a_in_ready, a_wr_en, a_mac_clr, a_mac_en, a_bias_add, a_out_valid, a_frame_done, a_busy, a_drop_err, a_class_valid;
  logic [3:0] a_wr_col, a_out_idx, a_class_id;
  logic [7:0] a_rd_addr;
  logic [10:0] a_w_addr;
  logic b_in_ready, b_wr_en, b_mac_clr, b_mac_en, b_bias_add, b_out_valid, b_frame_done, b_busy, b_drop_err, b_class_valid;
  logic [3:0] b_wr_col, b_out_idx, b_class_id;
  logic [7:0] b_rd_addr;
  logic [10:0] b_w_addr;

  logic m_in_ready, m_wr_en, m_mac_clr, m_mac_en, m_bias_add, m_out_valid, m_frame_done, m_busy, m_class_valid;
  logic [3:0] m_wr_col, m_out_idx, m_class_id;
  logic [7:0] m_rd_addr;
  logic [10:0] m_w_addr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

`ifdef FC_ARGMAX_EN
  logic [ACC_W-1:0] acc_tab [OUTPUT_NUM];
  initial acc_tab = '{ACC_W'(-5), ACC_W'(100), ACC_W'(7), ACC_W'(100), ACC_W'(-20000),
                      ACC_W'(3), ACC_W'(0), ACC_W'(99), ACC_W'(1), ACC_W'(2)};
`endif

  always #5 clk = ~clk;

  fc_sequencer #(.RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_a), .in_ready(a_in_ready), .wr_en(a_wr_en),
    .wr_col(a_wr_col), .rd_addr(a_rd_addr), .w_addr(a_w_addr), .mac_clr(a_mac_clr),
    .mac_en(a_mac_en), .bias_add(a_bias_add), .out_idx(a_out_idx), .out_valid(a_out_valid),
    .frame_done(a_frame_done), .busy(a_busy), .drop_err(a_drop_err), .acc_in(acc_in),
    .class_id(a_class_id), .class_valid(a_class_valid)
  );

  fc_sequencer #(.RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .valid_in(valid_b), .in_ready(b_in_ready), .wr_en(b_wr_en),
    .wr_col(b_wr_col), .rd_addr(b_rd_addr), .w_addr(b_w_addr), .mac_clr(b_mac_clr),
    .mac_en(b_mac_en), .bias_add(b_bias_add), .out_idx(b_out_idx), .out_valid(b_out_valid),
    .frame_done(b_frame_done), .busy(b_busy), .drop_err(b_drop_err), .acc_in(acc_in),
    .class_id(b_class_id), .class_valid(b_class_valid)
  );

  assign m_in_ready    = sel ? b_in_ready    : a_in_ready;
  assign m_wr_en       = sel ? b_wr_en       : a_wr_en;
  assign m_wr_col      = sel ? b_wr_col      : a_wr_col;
  assign m_rd_addr     = sel ? b_rd_addr     : a_rd_addr;
  assign m_w_addr      = sel ? b_w_addr      : a_w_addr;
  assign m_mac_clr     = sel ? b_mac_clr     : a_mac_clr;
  assign m_mac_en      = sel ? b_mac_en      : a_mac_en;
  assign m_bias_add    = sel ? b_bias_add    : a_bias_add;
  assign m_out_idx     = sel ? b_out_idx     : a_out_idx;
  assign m_out_valid   = sel ? b_out_valid   : a_out_valid;
  assign m_frame_done  = sel ? b_frame_done  : a_frame_done;
  assign m_busy        = sel ? b_busy        : a_busy;
  assign m_class_id    = sel ? b_class_id    : a_class_id;
  assign m_class_valid = sel ? b_class_valid : a_class_valid;

  typedef struct {
    logic       valid;
    logic       wr_en;
    logic [3:0] wr_col;
    logic       in_ready;
    logic       busy;
    logic       mac_clr;
    logic       mac_en;
    logic [7:0] rd_addr;
    logic       drop_err;
  } vec_t;

  vec_t tab [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_valid(input logic v);
    if (sel) valid_b = v;
    else valid_a = v;
  endtask

  // Drives beats from column c0 to the end of the frame; L returns the cycle of the last beat.
  task automatic load_frame(input int c0, input bit gaps, output int L);
    for (int i = c0; i < 16; i++) begin
      set_valid(1'b1); #1;
      chk("ld_col", m_wr_col, i);
      chk("ld_wr", m_wr_en, 1);
      L = cyc;
      tick();
      if (gaps && i < 15) begin
        set_valid(1'b0); #1;
        chk("ld_gap_wr", m_wr_en, 0);
        chk("ld_gap_col", m_wr_col, i + 1);
        tick();
      end
    end
    set_valid(1'b0); #1;
    chk("ld_clr", m_mac_clr, 1);
    chk("ld_ready_low", m_in_ready, 0);
    tick();
  endtask

  // Observes one frame of compute starting 2 cycles after the last beat at cycle L.
  task automatic run_frame(input int L, input int lat, input bit hold);
    int k, mac_cnt, first_mac, last_mac, ovl, wr_busy, w_min, w_max, w_bad, budget;
    k = 0; mac_cnt = 0; first_mac = -1; last_mac = -1; ovl = 0; wr_busy = 0;
    w_min = 99999; w_max = -1; w_bad = 0; budget = 1700;
    while (k < OUTPUT_NUM && budget > 0) begin
      set_valid(hold);
`ifdef FC_ARGMAX_EN
      acc_in = acc_tab[m_out_idx];
`endif
      #1;
      if (m_mac_en && (m_mac_clr || m_bias_add)) ovl++;
      if (m_wr_en) wr_busy++;
      if (m_mac_en) begin
        mac_cnt++;
        if (first_mac < 0) first_mac = cyc;
        last_mac = cyc;
      end
      if (m_bias_add) chk("bias_after_mac", cyc - last_mac, 1);
      if (m_out_idx == 4'd3 && m_busy) begin
        if (int'(m_w_addr) < w_min) w_min = int'(m_w_addr);
        if (int'(m_w_addr) > w_max) w_max = int'(m_w_addr);
        if (int'(m_w_addr) != 432 + int'(m_rd_addr)) w_bad++;
      end
      if (m_out_valid) begin
        chk("ov_cycle", cyc - L, (k + 1) * (lat + 147));
        chk("ov_idx", m_out_idx, k);
        chk("mac_per_neuron", mac_cnt, 144);
        chk("frame_done", m_frame_done, 32'(k == OUTPUT_NUM - 1));
        mac_cnt = 0;
        k++;
      end else if (m_frame_done) begin
        ovl++;
      end
      tick();
      budget--;
    end
    if (k < OUTPUT_NUM) chk("frame_timeout_neurons", k, OUTPUT_NUM);
    chk("first_mac_latency", first_mac - L, 2 + lat);
    chk("strobe_overlap", ovl, 0);
    chk("wr_during_compute", wr_busy, 0);
    chk("n3_w_min", w_min, 432);
    chk("n3_w_max", w_max, 575);
    chk("n3_w_rel", w_bad, 0);
    set_valid(hold); #1;
`ifdef FC_ARGMAX_EN
    chk("class_valid", m_class_valid, 1);
    chk("class_id", m_class_id, 1);
`else
    chk("class_valid_off", m_class_valid, 0);
    chk("class_id_off", m_class_id, 0);
`endif
    chk("ready_after_done", m_in_ready, 1);
    chk("busy_after_done", m_busy, 0);
    chk("wr_after_done", m_wr_en, hold);
    chk("col_after_done", m_wr_col, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int L, wt, idle_bad;

    for (int i = 0; i < 16; i++)
      tab[i] = '{1'b1, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tab[16] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0};

    tick(); #1;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_mac_clr", a_mac_clr, 0);
    chk("rst_mac_en", a_mac_en, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_frame_done", a_frame_done, 0);
    chk("rst_rd_addr", a_rd_addr, 0);
    chk("rst_w_addr", a_w_addr, 0);
    chk("rst_out_idx", a_out_idx, 0);
    chk("rst_drop_err", a_drop_err, 0);
    chk("rst_class_valid", a_class_valid, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    rst = 1'b0;
    tick();

    sel = 1'b0;
    L = 0;
    for (int i = 0; i < 17; i++) begin
      valid_a = tab[i].valid; #1;
      chk("t_wr_en", a_wr_en, tab[i].wr_en);
      chk("t_wr_col", a_wr_col, tab[i].wr_col);
      chk("t_in_ready", a_in_ready, tab[i].in_ready);
      chk("t_busy", a_busy, tab[i].busy);
      chk("t_mac_clr", a_mac_clr, tab[i].mac_clr);
      chk("t_mac_en", a_mac_en, tab[i].mac_en);
      chk("t_rd_addr", a_rd_addr, tab[i].rd_addr);
      chk("t_drop_err", a_drop_err, tab[i].drop_err);
      if (i == 15) L = cyc;
      tick();
    end

    // Frame 1 with valid_in held high throughout compute.
    run_frame(L, 1, 1'b1);
    chk("drop_err_sticky", a_drop_err, 1);
    tick();

    // Frame 2 (first beat already taken), then reset during neuron 5 MAC.
    load_frame(1, 1'b1, L);
    wt = 0;
    while (!(a_out_idx == 4'd5 && a_mac_en) && wt < 2000) begin
      tick();
      wt++;
    end
    chk("reach_neuron5", 32'(wt < 2000), 1);
    repeat (20) tick();
    #1;
    chk("pre_rst_mac_en", a_mac_en, 1);
    chk("pre_rst_idx", a_out_idx, 5);
    rst = 1'b1; #1;
    chk("arst_mac_en", a_mac_en, 0);
    chk("arst_out_idx", a_out_idx, 0);
    chk("arst_rd_addr", a_rd_addr, 0);
    chk("arst_w_addr", a_w_addr, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_in_ready", a_in_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    idle_bad = 0;
    for (int t = 0; t < 300; t++) begin
      #1;
      if (a_out_valid || a_frame_done || a_busy || a_mac_en || !a_in_ready) idle_bad++;
      tick();
    end
    chk("post_rst_idle", idle_bad, 0);
    chk("post_rst_drop_err", a_drop_err, 0);

    // Fresh frame with gapped input on the RD_LAT=1 instance.
    load_frame(0, 1'b1, L);
    run_frame(L, 1, 1'b0);
    tick();

    // RD_LAT=3 instance.
    sel = 1'b1;
    load_frame(0, 1'b0, L);
    run_frame(L, 3, 1'b0);
    chk("b_drop_err", b_drop_err, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
